coin_value_encoder: RTL and testbench

- Parametrised, registered successor to the vending machine's combinational coin priority encoder.
- Takes NUM_COINS raw coin-sensor lines and detects rising edges on each.
- Latches each edge as a pending event and issues events one at a time, highest channel first, as {channel index, coin value} on a valid/ready handshake.
- Sits between the coin sensors and the credit/FSM logic; no coin event is lost when several coins arrive together.

---
 rtl/vm_pkg.sv | 21 ++
 rtl/prio_pick.sv | 22 ++
 rtl/coin_value_encoder.sv | 86 ++++++++
 tb/tb_coin_value_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin value table, channel indices and
// the coin event FSM state type.
package vm_pkg;

  localparam int VM_VAL_W     = 4;
  localparam int VM_NUM_COINS = 4;

  // Slice i holds the value of channel i.
  localparam logic [VM_NUM_COINS*VM_VAL_W-1:0] VM_COIN_VALS = {4'd10, 4'd5, 4'd2, 4'd1};

  localparam int COIN_1  = 0;
  localparam int COIN_2  = 1;
  localparam int COIN_5  = 2;
  localparam int COIN_10 = 3;

  typedef enum logic {
    IDLE,
    HOLD
  } fsm_state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder: returns the index of the highest
// asserted request and a flag saying whether any request is asserted.
module prio_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: idx gets a default before the loop, so no latch is inferred when req is zero.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/coin_value_encoder.sv
// Registered coin priority encoder: edge-detects coin sensor lines, queues one
// pending event per channel and hands them out highest channel first.
module coin_value_encoder
  import vm_pkg::*;
#(
  parameter int                           NUM_COINS = VM_NUM_COINS,
  parameter int                           VAL_W     = VM_VAL_W,
  parameter logic [NUM_COINS*VAL_W-1:0]   COIN_VALS = VM_COIN_VALS,
  parameter int                           IDX_W     = $clog2(NUM_COINS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic                 enable,
  output logic                 coin_valid,
  input  logic                 coin_ready,
  output logic [IDX_W-1:0]     coin_idx,
  output logic [VAL_W-1:0]     coin_value,
  output logic [NUM_COINS-1:0] pending,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  fsm_state_t           state;
  logic [NUM_COINS-1:0] prev;
  logic [NUM_COINS-1:0] new_set;
  logic [NUM_COINS-1:0] clear_mask;
  logic [NUM_COINS-1:0] dup;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [VAL_W-1:0]     pick_value;
  logic                 load;

  prio_pick #(.N(NUM_COINS), .IDX_W(IDX_W)) u_pick (
    .req (pending),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_value = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (pick_idx == IDX_W'(i)) pick_value = COIN_VALS[i*VAL_W +: VAL_W];
    end
  end

  // A new event is taken whenever the output slot is empty or being consumed.
  assign load       = pick_any && ((state == IDLE) || (coin_valid && coin_ready));
  assign clear_mask = load ? (NUM_COINS'(1) << pick_idx) : '0;
  assign new_set    = enable ? (coin_in & ~prev) : '0;
  // An edge on the channel being handed out this cycle simply re-arms it.
  assign dup        = new_set & pending & ~clear_mask;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      prev    <= coin_in;
      pending <= (pending & ~clear_mask) | new_set;
      if (clr_overrun)  overrun <= 1'b0;
      else if (|dup)    overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      coin_valid <= 1'b0;
      coin_idx   <= '0;
      coin_value <= '0;
    end else if (load) begin
      state      <= HOLD;
      coin_valid <= 1'b1;
      coin_idx   <= pick_idx;
      coin_value <= pick_value;
    end else if (state == HOLD && coin_ready) begin
      state      <= IDLE;
      coin_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coin_value_encoder.sv
// Directed bench for coin_value_encoder: reset, single and simultaneous coins,
// backpressure, overrun, re-arm on load, enable masking and async reset.
module tb_coin_value_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] coin_in;
  logic       enable;
  logic       coin_valid;
  logic       coin_ready;
  logic [1:0] coin_idx;
  logic [3:0] coin_value;
  logic [3:0] pending;
  logic       overrun;
  logic       clr_overrun;

  int errors = 0;
  int checks = 0;

  coin_value_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in     (coin_in),
    .enable      (enable),
    .coin_valid  (coin_valid),
    .coin_ready  (coin_ready),
    .coin_idx    (coin_idx),
    .coin_value  (coin_value),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; all drives and samples happen there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event word {valid, idx, value} and pending flags compared against hand values.
  task automatic expect_ev(input string name, input logic v, input logic [1:0] idx,
                           input logic [3:0] val, input logic [3:0] pend);
    checks++;
    if ({coin_valid, coin_idx, coin_value, pending} !== {v, idx, val, pend}) begin
      errors++;
      $display("FAIL %s: got valid=%0b idx=%0d value=%0d pending=%b, want valid=%0b idx=%0d value=%0d pending=%b",
               name, coin_valid, coin_idx, coin_value, pending, v, idx, val, pend);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coin_in = 4'b0000; enable = 1'b1; coin_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) tick();
    expect_ev("reset_state", 1'b0, 2'd0, 4'd0, 4'b0000);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: got %0b want 0", overrun);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (coin_valid !== 1'b0) begin
        errors++; $display("FAIL idle_valid cycle %0d: got %0b want 0", i, coin_valid);
      end
    end
  endtask

  task automatic test_single();
    coin_ready = 1'b1;
    coin_in = 4'b0100;
    tick(); coin_in = 4'b0000;
    expect_ev("single_pending", 1'b0, 2'd0, 4'd0, 4'b0100);
    tick();
    expect_ev("single_event", 1'b1, 2'd2, 4'd5, 4'b0000);
    tick();
    expect_ev("single_drop", 1'b0, 2'd2, 4'd5, 4'b0000);
  endtask

  task automatic test_simultaneous();
    logic [3:0] vals [4] = '{4'd1, 4'd2, 4'd5, 4'd10};
    logic [3:0] left;
    coin_ready = 1'b1;
    coin_in = 4'b1111;
    tick(); coin_in = 4'b0000;
    expect_ev("simul_pending", 1'b0, 2'd2, 4'd5, 4'b1111);
    left = 4'b1111;
    for (int ch = 3; ch >= 0; ch--) begin
      left[ch] = 1'b0;
      tick();
      expect_ev($sformatf("simul_event_ch%0d", ch), 1'b1, 2'(ch), vals[ch], left);
    end
    tick();
    expect_ev("simul_drop", 1'b0, 2'd0, 4'd1, 4'b0000);
  endtask

  task automatic test_backpressure();
    coin_ready = 1'b0;
    coin_in = 4'b1001;
    tick(); coin_in = 4'b0000;
    expect_ev("bp_pending", 1'b0, 2'd0, 4'd1, 4'b1001);
    tick();
    expect_ev("bp_first", 1'b1, 2'd3, 4'd10, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_ev($sformatf("bp_hold_%0d", i), 1'b1, 2'd3, 4'd10, 4'b0001);
    end
    coin_ready = 1'b1;
    tick();
    expect_ev("bp_second", 1'b1, 2'd0, 4'd1, 4'b0000);
    tick();
    expect_ev("bp_drop", 1'b0, 2'd0, 4'd1, 4'b0000);
  endtask

  task automatic test_overrun();
    coin_ready = 1'b0;
    coin_in = 4'b1001;
    tick(); coin_in = 4'b0000;
    tick();
    expect_ev("ovr_hold", 1'b1, 2'd3, 4'd10, 4'b0001);
    coin_in = 4'b0001;
    tick(); coin_in = 4'b0000;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got %0b want 1", overrun);
    end
    expect_ev("ovr_dup_dropped", 1'b1, 2'd3, 4'd10, 4'b0001);
    coin_ready = 1'b1;
    tick();
    expect_ev("ovr_drain_ch0", 1'b1, 2'd0, 4'd1, 4'b0000);
    tick();
    expect_ev("ovr_only_one", 1'b0, 2'd0, 4'd1, 4'b0000);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %0b want 1", overrun);
    end
    clr_overrun = 1'b1;
    tick(); clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %0b want 0", overrun);
    end
  endtask

  task automatic test_rearm_on_load();
    coin_ready = 1'b1;
    coin_in = 4'b1001;
    tick(); coin_in = 4'b0000;
    tick();
    expect_ev("rearm_first", 1'b1, 2'd3, 4'd10, 4'b0001);
    coin_in = 4'b0001;
    tick(); coin_in = 4'b0000;
    expect_ev("rearm_load", 1'b1, 2'd0, 4'd1, 4'b0001);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL rearm_no_overrun: got %0b want 0", overrun);
    end
    tick();
    expect_ev("rearm_again", 1'b1, 2'd0, 4'd1, 4'b0000);
    tick();
    expect_ev("rearm_drop", 1'b0, 2'd0, 4'd1, 4'b0000);
  endtask

  task automatic test_enable();
    coin_ready = 1'b1;
    enable = 1'b0;
    coin_in = 4'b0010;
    tick(); coin_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      expect_ev($sformatf("enable_masked_%0d", i), 1'b0, 2'd0, 4'd1, 4'b0000);
      tick();
    end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    coin_ready = 1'b0;
    coin_in = 4'b1001;
    tick(); coin_in = 4'b0000;
    tick();
    expect_ev("areset_before", 1'b1, 2'd3, 4'd10, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    expect_ev("areset_immediate", 1'b0, 2'd0, 4'd0, 4'b0000);
    tick(); tick();
    rst_n = 1'b1;
    coin_ready = 1'b1;
    tick(); tick();
    expect_ev("areset_dropped", 1'b0, 2'd0, 4'd0, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overrun();
    test_rearm_on_load();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
